lcd_pattern_source: RTL and testbench

- Upstream byte source for the LCD 8080-bus write engine.
- On each frame-mark (tearing-effect) rising edge, emits one full frame: command byte 0x2C (memory write) followed by WIDTH*HEIGHT RGB565 pixels as high/low byte pairs.
- Bytes go out over a valid/ready handshake tagged with the RS level.
- Used for panel bring-up and as the default image source until the SPI pixel path lands.

---
 rtl/lcd_pattern_source_if.sv | 11 +
 rtl/lcd_pattern_source.sv | 177 +++++++++++++++++
 tb/tb_lcd_pattern_source.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/lcd_pattern_source_if.sv
// Byte stream from lcd_pattern_source to the 8080-bus writer: data, RS tag and
// valid/ready handshake.
interface lcd_pattern_source_if;
  logic [7:0] o_data;
  logic       o_rs;
  logic       o_valid;
  logic       i_ready;

  modport master (output o_data, output o_rs, output o_valid, input i_ready);
  modport slave  (input o_data, input o_rs, input o_valid, output i_ready);
endinterface

// File: rtl/lcd_pattern_source.sv
// Test-pattern byte source for the LCD write engine: one 0x2C command plus a full
// RGB565 frame per frame-mark edge. Optional overrun flag: LCD_PATTERN_SOURCE_OVERRUN_EN.
module lcd_pattern_source #(
  parameter int WIDTH  = 320,
  parameter int HEIGHT = 240
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic                  i_enable,
  input  logic                  i_lcd_fmark,
  input  logic [1:0]            i_pattern,
  lcd_pattern_source_if.master  bus,
  output logic                  o_busy,
  output logic [15:0]           o_frame_count,
  input  logic                  i_clear_overrun,
  output logic                  o_overrun
);

  typedef enum logic [1:0] {IDLE, CMD, PIX_HI, PIX_LO} state_t;

  localparam logic [8:0] X_LAST   = 9'(WIDTH - 1);
  localparam logic [7:0] Y_LAST   = 8'(HEIGHT - 1);
  localparam logic [8:0] BAR_LAST = 9'(WIDTH / 8 - 1);

  state_t      r_state, w_next;
  logic [2:0]  r_fm;
  logic [8:0]  r_x, r_bar_cnt;
  logic [7:0]  r_y;
  logic [2:0]  r_bar_idx;
  logic [1:0]  r_pattern;
  logic [15:0] r_frame_count;
  logic [15:0] w_pix;
  logic [7:0]  w_data;
  logic        w_rs, w_valid, w_edge, w_start, w_adv, w_done, w_last;

  function automatic logic [15:0] bar_color(input logic [2:0] idx);
    case (idx)
      3'd0:    return 16'hFFFF;
      3'd1:    return 16'hFFE0;
      3'd2:    return 16'h07FF;
      3'd3:    return 16'h07E0;
      3'd4:    return 16'hF81F;
      3'd5:    return 16'hF800;
      3'd6:    return 16'h001F;
      default: return 16'h0000;
    endcase
  endfunction

  // r_fm[1:0] is the 2-FF synchroniser, r_fm[2] the edge-detect delay
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) r_fm <= 3'b000;
    else            r_fm <= {r_fm[1], r_fm[0], i_lcd_fmark};
  end

  assign w_edge = r_fm[1] & ~r_fm[2];
  assign w_last = (r_x == X_LAST) && (r_y == Y_LAST);

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) r_state <= IDLE;
    else            r_state <= w_next;
  end

  // Outputs depend on state only; i_ready only steers the next state
  always_comb begin
    w_next  = r_state;
    w_valid = 1'b0;
    w_rs    = 1'b0;
    w_data  = 8'h00;
    w_start = 1'b0;
    w_adv   = 1'b0;
    w_done  = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_edge && i_enable) begin
          w_start = 1'b1;
          w_next  = CMD;
        end
      end
      CMD: begin
        w_valid = 1'b1;
        w_data  = 8'h2C;
        if (bus.i_ready) w_next = PIX_HI;
      end
      PIX_HI: begin
        w_valid = 1'b1;
        w_rs    = 1'b1;
        w_data  = w_pix[15:8];
        if (bus.i_ready) w_next = PIX_LO;
      end
      PIX_LO: begin
        w_valid = 1'b1;
        w_rs    = 1'b1;
        w_data  = w_pix[7:0];
        if (bus.i_ready) begin
          if (w_last) begin
            w_done = 1'b1;
            w_next = IDLE;
          end else begin
            w_adv  = 1'b1;
            w_next = PIX_HI;
          end
        end
      end
      default: w_next = IDLE;
    endcase
  end

  // Frame count only moves at frame end, so it still holds the start-of-frame value here
  always_comb begin
    w_pix = 16'h0000;
    case (r_pattern)
      2'd0:    w_pix = bar_color(r_bar_idx);
      2'd1:    w_pix = (r_x[4] ^ r_y[4]) ? 16'hFFFF : 16'h0000;
      2'd2:    w_pix = {r_x[8:4], r_y[7:2], r_frame_count[4:0]};
      default: w_pix = 16'h0000;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_x           <= '0;
      r_y           <= '0;
      r_bar_cnt     <= '0;
      r_bar_idx     <= '0;
      r_pattern     <= '0;
      r_frame_count <= '0;
    end else begin
      if (w_start) begin
        r_x       <= '0;
        r_y       <= '0;
        r_bar_cnt <= '0;
        r_bar_idx <= '0;
        r_pattern <= i_pattern;
      end else if (w_adv) begin
        if (r_x == X_LAST) begin
          r_x       <= '0;
          r_y       <= r_y + 8'd1;
          r_bar_cnt <= '0;
          r_bar_idx <= '0;
        end else begin
          r_x <= r_x + 9'd1;
          if (r_bar_cnt == BAR_LAST) begin
            r_bar_cnt <= '0;
            r_bar_idx <= r_bar_idx + 3'd1;
          end else begin
            r_bar_cnt <= r_bar_cnt + 9'd1;
          end
        end
      end
      if (w_done) r_frame_count <= r_frame_count + 16'd1;
    end
  end

`ifdef LCD_PATTERN_SOURCE_OVERRUN_EN
  logic r_overrun;

  // Set has priority over a clear in the same cycle
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n)                          r_overrun <= 1'b0;
    else if (w_edge && o_busy && i_enable)   r_overrun <= 1'b1;
    else if (i_clear_overrun)                r_overrun <= 1'b0;
  end

  assign o_overrun = r_overrun;
`else
  logic w_unused_clear;
  assign w_unused_clear = i_clear_overrun;
  assign o_overrun      = 1'b0;
`endif

  assign o_busy        = (r_state != IDLE);
  assign o_frame_count = r_frame_count;
  assign bus.o_valid   = w_valid;
  assign bus.o_rs      = w_rs;
  assign bus.o_data    = w_data;

endmodule

// File: tb/tb_lcd_pattern_source.sv
// Bench for lcd_pattern_source: random-stall frame capture compared against a
// frame model built from pixel coordinates with plain arithmetic.
module tb_lcd_pattern_source;
  localparam int W = 32;
  localparam int H = 20;
  localparam int FRAME_LEN = 1 + 2 * W * H;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        fmark = 1'b0;
  logic        clr = 1'b0;
  logic [1:0]  pat = 2'd0;
  logic        busy, ovr;
  logic [15:0] fc;

  lcd_pattern_source_if bus();

  lcd_pattern_source #(.WIDTH(W), .HEIGHT(H)) dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_enable(en), .i_lcd_fmark(fmark),
    .i_pattern(pat), .bus(bus), .o_busy(busy), .o_frame_count(fc),
    .i_clear_overrun(clr), .o_overrun(ovr)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int exp_fc = 0;
  logic [8:0] got_q[$];
  logic [8:0] exp_q[$];

  function automatic logic [15:0] ref_pix(int x, int y, int p, int f);
    logic [15:0] bars [8];
    bars = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0, 16'hF81F, 16'hF800, 16'h001F, 16'h0000};
    case (p)
      0: return bars[x / (W / 8)];
      1: return ((((x / 16) + (y / 16)) % 2) == 1) ? 16'hFFFF : 16'h0000;
      2: return 16'(((x / 16) % 32) * 2048 + ((y / 4) % 64) * 32 + (f % 32));
      default: return 16'h0000;
    endcase
  endfunction

  task automatic build_expected(input int p, input int f);
    logic [15:0] px;
    exp_q.delete();
    exp_q.push_back(9'h02C);
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) begin
        px = ref_pix(x, y, p, f);
        exp_q.push_back({1'b1, px[15:8]});
        exp_q.push_back({1'b1, px[7:0]});
      end
  endtask

  function automatic int stream_diff();
    int d = 0;
    int n;
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    if (got_q.size() != exp_q.size()) d++;
    for (int i = 0; i < n; i++)
      if (got_q[i] !== exp_q[i]) d++;
    return d;
  endfunction

  task automatic pulse_fmark();
    @(negedge clk) fmark = 1'b1;
    repeat (4) @(negedge clk);
    fmark = 1'b0;
  endtask

  // Collects transferred bytes until o_busy falls, with stall_pct% random stalls
  task automatic capture_frame(input int stall_pct, output int hold_err, output bit tmo);
    int n;
    logic pv, pr, prs;
    logic [7:0] pd;
    got_q.delete();
    hold_err = 0;
    tmo = 1'b0;
    n = 0;
    while (!busy && n < 20) begin @(negedge clk); n++; end
    if (!busy) begin tmo = 1'b1; return; end
    n = 0; pv = 1'b0; pr = 1'b1; pd = 8'h00; prs = 1'b0;
    while (busy && n < 6 * FRAME_LEN) begin
      if (pv && !pr && (bus.o_valid !== 1'b1 || bus.o_data !== pd || bus.o_rs !== prs))
        hold_err++;
      bus.i_ready = ($urandom_range(99) >= stall_pct);
      if (bus.o_valid && bus.i_ready) got_q.push_back({bus.o_rs, bus.o_data});
      pv = bus.o_valid; pr = bus.i_ready; pd = bus.o_data; prs = bus.o_rs;
      @(negedge clk);
      n++;
    end
    if (busy) tmo = 1'b1;
    bus.i_ready = 1'b0;
  endtask

  task automatic test_reset();
    tests++; if (bus.o_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %0b expected 0", bus.o_valid); end
    tests++; if (bus.o_data !== 8'h00) begin fails++; $display("FAIL reset_data: got %h expected 00", bus.o_data); end
    tests++; if (bus.o_rs !== 1'b0) begin fails++; $display("FAIL reset_rs: got %0b expected 0", bus.o_rs); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %0b expected 0", busy); end
    tests++; if (fc !== 16'd0) begin fails++; $display("FAIL reset_fc: got %0d expected 0", fc); end
    tests++; if (ovr !== 1'b0) begin fails++; $display("FAIL reset_overrun: got %0b expected 0", ovr); end
  endtask

  task automatic test_enable_off();
    bit seen_v = 1'b0, seen_b = 1'b0;
    en = 1'b0;
    fork
      pulse_fmark();
      repeat (12) begin @(negedge clk); seen_v |= bus.o_valid; seen_b |= busy; end
    join
    tests++; if (seen_v !== 1'b0) begin fails++; $display("FAIL enable_off_valid: got %0b expected 0", seen_v); end
    tests++; if (seen_b !== 1'b0) begin fails++; $display("FAIL enable_off_busy: got %0b expected 0", seen_b); end
    en = 1'b1;
  endtask

  task automatic test_frame(input int p, input int stall, input string name);
    int herr; bit tmo; int d;
    pat = 2'(p);
    build_expected(p, exp_fc);
    pulse_fmark();
    capture_frame(stall, herr, tmo);
    exp_fc = (exp_fc + 1) % 65536;
    d = stream_diff();
    tests++; if (tmo) begin fails++; $display("FAIL %s_timeout: got timeout expected frame end", name); end
    tests++; if (got_q.size() != FRAME_LEN) begin fails++; $display("FAIL %s_len: got %0d expected %0d", name, got_q.size(), FRAME_LEN); end
    tests++; if (d != 0) begin fails++; $display("FAIL %s_stream: got %0d differing bytes expected 0", name, d); end
    tests++; if (herr != 0) begin fails++; $display("FAIL %s_stall_hold: got %0d changes expected 0", name, herr); end
    tests++; if (fc !== 16'(exp_fc)) begin fails++; $display("FAIL %s_fc: got %0d expected %0d", name, fc, exp_fc); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL %s_busy_end: got %0b expected 0", name, busy); end
  endtask

  task automatic test_overrun();
    int herr; bit tmo; bit seen_b = 1'b0;
    pat = 2'd3;
    build_expected(3, exp_fc);
    fork
      begin pulse_fmark(); capture_frame(0, herr, tmo); end
      begin repeat (200) @(negedge clk); pulse_fmark(); end
    join
    exp_fc = (exp_fc + 1) % 65536;
    tests++; if (got_q.size() != FRAME_LEN || tmo) begin fails++; $display("FAIL overrun_len: got %0d expected %0d", got_q.size(), FRAME_LEN); end
    tests++; if (stream_diff() != 0) begin fails++; $display("FAIL overrun_stream: got %0d differing bytes expected 0", stream_diff()); end
    repeat (10) begin @(negedge clk); seen_b |= busy; end
    tests++; if (seen_b !== 1'b0) begin fails++; $display("FAIL overrun_no_restart: got busy %0b expected 0", seen_b); end
`ifdef LCD_PATTERN_SOURCE_OVERRUN_EN
    tests++; if (ovr !== 1'b1) begin fails++; $display("FAIL overrun_set: got %0b expected 1", ovr); end
    clr = 1'b1; @(negedge clk); clr = 1'b0; @(negedge clk);
    tests++; if (ovr !== 1'b0) begin fails++; $display("FAIL overrun_clear: got %0b expected 0", ovr); end
`else
    tests++; if (ovr !== 1'b0) begin fails++; $display("FAIL overrun_tied: got %0b expected 0", ovr); end
`endif
  endtask

  task automatic test_reset_mid();
    int n = 0;
    pat = 2'd1;
    pulse_fmark();
    while (!busy && n < 20) begin @(negedge clk); n++; end
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL rstmid_start: got busy %0b expected 1", busy); end
    bus.i_ready = 1'b1;
    repeat (2) @(negedge clk);
    bus.i_ready = 1'b0;
    tests++; if (bus.o_valid !== 1'b1 || bus.o_rs !== 1'b1) begin fails++; $display("FAIL rstmid_pixlo: got valid %0b rs %0b expected 1 1", bus.o_valid, bus.o_rs); end
    #2 rst_n = 1'b0;
    #1;
    tests++; if (bus.o_valid !== 1'b0) begin fails++; $display("FAIL rstmid_valid: got %0b expected 0", bus.o_valid); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rstmid_busy: got %0b expected 0", busy); end
    tests++; if (fc !== 16'd0) begin fails++; $display("FAIL rstmid_fc: got %0d expected 0", fc); end
    @(negedge clk) rst_n = 1'b1;
    exp_fc = 0;
    test_frame(3, 30, "after_reset");
    tests++; if (got_q.size() == 0 || got_q[0] !== 9'h02C) begin fails++; $display("FAIL after_reset_first: got %h expected 02c", (got_q.size() == 0) ? 9'h1FF : got_q[0]); end
  endtask

  task automatic test_gradient();
    int bad;
    logic [8:0] b;
    for (int f = 0; f < 2; f++) begin
      test_frame(2, 20, "gradient");
      bad = 0;
      for (int i = 2; i < got_q.size(); i += 2) begin
        b = got_q[i];
        if (b[4:0] !== 5'(exp_fc - 1)) bad++;
      end
      tests++; if (bad != 0) begin fails++; $display("FAIL gradient_low5_f%0d: got %0d bad pixels expected 0", f, bad); end
    end
  endtask

  initial begin
    bus.i_ready = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    @(negedge clk);
    test_enable_off();
    test_frame(3, 0, "black");
    test_frame(0, 0, "bars");
    test_frame(1, 50, "checker_stall");
    test_overrun();
    test_reset_mid();
    test_gradient();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
